instr_sequencer: RTL

// - Control end of the picoMIPS core: fetches instruction words from the program ROM, decodes them and

---
 rtl/cpuConfig.sv | 38 +++
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/button_sync.sv | 23 ++
 rtl/instr_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cpuConfig.sv
// picoMIPS control configuration.
// Opcodes, ALU function codes and sequencer states.
package cpuConfig;

  localparam int OP_SIZE = 4;

  typedef enum logic [OP_SIZE-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUB  = 4'd3,
    OP_SUBI = 4'd4,
    OP_MUL  = 4'd5,
    OP_MULI = 4'd6,
    OP_MOVI = 4'd7,
    OP_LDSW = 4'd8,
    OP_JMP  = 4'd9,
    OP_BZ   = 4'd10,
    OP_WAIT = 4'd11,
    OP_HALT = 4'd12
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_MUL   = 2'd2,
    ALU_PASSB = 2'd3
  } aluFunc_t;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXEC    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    HALT    = 3'd4
  } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// ROM fetch bus and datapath control bundle.
// master = sequencer, slave = ROM/datapath side.
interface instr_sequencer_if
  import cpuConfig::*;
#(
  parameter int N      = 8,
  parameter int R_SIZE = 3,
  parameter int P      = 5
) ();

  logic [P-1:0]                  progAddr;
  logic [OP_SIZE+R_SIZE+N-1:0]   progData;
  logic                          aluZero;
  logic                          writeReg;
  aluFunc_t                      aluFunc;
  logic                          aluImmediate;
  logic                          immSwitches;
  logic [R_SIZE-1:0]             opD;
  logic [N-1:0]                  opS;

  modport master (
    output progAddr, writeReg, aluFunc,
    output aluImmediate, immSwitches, opD, opS,
    input  progData, aluZero
  );

  modport slave (
    input  progAddr, writeReg, aluFunc,
    input  aluImmediate, immSwitches, opD, opS,
    output progData, aluZero
  );

endinterface

// File: rtl/button_sync.sv
// Two-flop synchroniser for the asynchronous go button.
// Output lags the raw input by two clocks.
module button_sync (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic meta;

  // shift the raw level through two flops
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      out  <= 1'b0;
    end else begin
      meta <= in;
      out  <= meta;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// picoMIPS control unit: fetch, decode, PC sequencing.
// Two cycles per instruction, plus button wait and halt.
module instr_sequencer
  import cpuConfig::*;
#(
  parameter int N      = 8,
  parameter int R_SIZE = 3,
  parameter int P      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic goIn,
  output logic halted,
  output logic waiting,
  instr_sequencer_if.master bus
);

  localparam int W = OP_SIZE + R_SIZE + N;

  state_t          st, st_n;
  logic [P-1:0]    pc, pc_n;
  logic            zFlag, zFlag_n;
  logic            goSync;

  opcode_t         op;
  logic [R_SIZE-1:0] dOp;
  logic [N-1:0]    sOp;
  logic [P-1:0]    tgt;
  logic [P-1:0]    pcInc;
  logic            exec;
  logic            isAlu, isImm, isSw;
  aluFunc_t        fn;

  button_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .in    (goIn),
    .out   (goSync)
  );

  assign op    = opcode_t'(bus.progData[W-1 -: OP_SIZE]);
  assign dOp   = bus.progData[R_SIZE+N-1 -: R_SIZE];
  assign sOp   = bus.progData[N-1:0];
  assign tgt   = sOp[P-1:0];
  assign pcInc = pc + P'(1);
  assign exec  = (st == EXEC) && !reset;

  // state, program counter and zero flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= FETCH;
      pc    <= '0;
      zFlag <= 1'b0;
    end else begin
      st    <= st_n;
      pc    <= pc_n;
      zFlag <= zFlag_n;
    end
  end

  // next-state, PC update and instruction decode
  always_comb begin
    st_n    = st;
    pc_n    = pc;
    zFlag_n = zFlag;
    isAlu   = 1'b0;
    isImm   = 1'b0;
    isSw    = 1'b0;
    fn      = ALU_ADD;
    case (st)
      FETCH: st_n = EXEC;
      EXEC: begin
        st_n = FETCH;
        pc_n = pcInc;
        case (op)
          OP_ADD:  isAlu = 1'b1;
          OP_ADDI: begin isAlu = 1'b1; isImm = 1'b1; end
          OP_SUB:  begin isAlu = 1'b1; fn = ALU_SUB; end
          OP_SUBI: begin
            isAlu = 1'b1; isImm = 1'b1; fn = ALU_SUB;
          end
          OP_MUL:  begin isAlu = 1'b1; fn = ALU_MUL; end
          OP_MULI: begin
            isAlu = 1'b1; isImm = 1'b1; fn = ALU_MUL;
          end
          OP_MOVI: begin
            isAlu = 1'b1; isImm = 1'b1; fn = ALU_PASSB;
          end
          OP_LDSW: begin
            isAlu = 1'b1; isImm = 1'b1; isSw = 1'b1;
            fn = ALU_PASSB;
          end
          OP_JMP:  pc_n = tgt;
          OP_BZ:   if (zFlag) pc_n = tgt;
          OP_WAIT: begin st_n = WAIT_HI; pc_n = pc; end
          OP_HALT: begin st_n = HALT; pc_n = pc; end
          default: ;
        endcase
        if (isAlu) zFlag_n = bus.aluZero;
      end
      WAIT_HI: if (goSync) st_n = WAIT_LO;
      WAIT_LO: begin
        if (!goSync) begin
          st_n = FETCH;
          pc_n = pcInc;
        end
      end
      HALT: st_n = HALT;
      default: st_n = FETCH;
    endcase
  end

  assign bus.progAddr     = pc;
  assign bus.writeReg     = exec & isAlu;
  assign bus.aluImmediate = exec & isImm;
  assign bus.immSwitches  = exec & isSw;
  assign bus.aluFunc      = exec ? fn : ALU_ADD;
  assign bus.opD          = exec ? dOp : '0;
  assign bus.opS          = exec ? sOp : '0;

  assign halted  = (st == HALT);
  assign waiting = (st == WAIT_HI) || (st == WAIT_LO);

endmodule
